// File: rtl/gslcd_fb_reader.sv
// gslcd framebuffer fetch engine: AXI4 INCR read bursts into the pixel FIFO.
// Define GSLCD_FB_READER_RCHECK_EN to enable RRESP/RLAST checking (rd_error).
module gslcd_fb_reader #(
   parameter int C_M00_AXI_ADDR_WIDTH = 32,
   parameter int C_M00_AXI_DATA_WIDTH = 32,
   parameter int C_M00_AXI_ID_WIDTH   = 1,
   parameter int C_M00_AXI_BURST_LEN  = 16,
   parameter int FRAME_WORDS          = 384000
) (
   input  logic                            m00_axi_aclk,
   input  logic                            m00_axi_areset,
   input  logic                            start,
   input  logic                            stop,
   input  logic [C_M00_AXI_ADDR_WIDTH-1:0] fb_base,
   input  logic [15:0]                     fifo_free,
   output logic                            fifo_wr_en,
   output logic [31:0]                     fifo_wr_data,
   output logic                            busy,
   output logic                            frame_done,
   output logic                            rd_error,
   output logic [C_M00_AXI_ID_WIDTH-1:0]   m00_axi_arid,
   output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
   output logic [7:0]                      m00_axi_arlen,
   output logic [2:0]                      m00_axi_arsize,
   output logic [1:0]                      m00_axi_arburst,
   output logic                            m00_axi_arlock,
   output logic [3:0]                      m00_axi_arcache,
   output logic [2:0]                      m00_axi_arprot,
   output logic [3:0]                      m00_axi_arqos,
   output logic                            m00_axi_arvalid,
   input  logic                            m00_axi_arready,
   input  logic [C_M00_AXI_ID_WIDTH-1:0]   m00_axi_rid,
   input  logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
   input  logic [1:0]                      m00_axi_rresp,
   input  logic                            m00_axi_rlast,
   input  logic                            m00_axi_rvalid,
   output logic                            m00_axi_rready
);

   localparam int AW     = C_M00_AXI_ADDR_WIDTH;
   localparam int NBURST = FRAME_WORDS / C_M00_AXI_BURST_LEN;
   localparam int BTW    = $clog2(C_M00_AXI_BURST_LEN);
   localparam int BCW    = (NBURST > 1) ? $clog2(NBURST) : 1;

   localparam logic [BTW-1:0] BEAT_LAST  = BTW'(C_M00_AXI_BURST_LEN - 1);
   localparam logic [BCW-1:0] BURST_LAST = BCW'(NBURST - 1);
   localparam logic [AW-1:0]  ADDR_STEP  = AW'(C_M00_AXI_BURST_LEN * 4);
   localparam logic [AW-1:0]  ALIGN_MASK = ~AW'(C_M00_AXI_BURST_LEN * 4 - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA} state_t;

   state_t         state_q, state_d;
   logic [AW-1:0]  base_q;
   logic [AW-1:0]  addr_q;
   logic [BTW-1:0] beat_q;
   logic [BCW-1:0] burst_q;
   logic           stop_pend_q;
   logic           err_q;
   logic           r_hs;
   logic           last_beat;
   logic           beat_err;
   logic           unused_r;

   assign m00_axi_arid    = '0;
   assign m00_axi_arlen   = 8'(C_M00_AXI_BURST_LEN - 1);
   assign m00_axi_arsize  = 3'b010;
   assign m00_axi_arburst = 2'b01;
   assign m00_axi_arlock  = 1'b0;
   assign m00_axi_arcache = 4'b0011;
   assign m00_axi_arprot  = 3'b000;
   assign m00_axi_arqos   = 4'b0000;
   assign m00_axi_araddr  = addr_q;
   assign m00_axi_arvalid = (state_q == S_ADDR);
   assign m00_axi_rready  = (state_q == S_DATA);
   assign busy            = (state_q != S_IDLE);
   assign rd_error        = err_q;

   assign r_hs      = m00_axi_rvalid && (state_q == S_DATA);
   assign last_beat = (beat_q == BEAT_LAST);

`ifdef GSLCD_FB_READER_RCHECK_EN
   assign beat_err = (m00_axi_rresp != 2'b00) || (m00_axi_rlast != last_beat);
   assign unused_r = ^m00_axi_rid;
`else
   assign beat_err = 1'b0;
   assign unused_r = ^{m00_axi_rid, m00_axi_rresp, m00_axi_rlast};
`endif

   always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
      if (m00_axi_areset) state_q <= S_IDLE;
      else                state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start) state_d = S_WAIT;
         S_WAIT: begin
            if (stop_pend_q || err_q)
               state_d = S_IDLE;
            else if (fifo_free >= 16'(C_M00_AXI_BURST_LEN))
               state_d = S_ADDR;
         end
         S_ADDR: if (m00_axi_arready) state_d = S_DATA;
         S_DATA: if (r_hs && last_beat) state_d = S_WAIT;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
      if (m00_axi_areset) begin
         base_q       <= '0;
         addr_q       <= '0;
         beat_q       <= '0;
         burst_q      <= '0;
         stop_pend_q  <= 1'b0;
         err_q        <= 1'b0;
         fifo_wr_en   <= 1'b0;
         fifo_wr_data <= '0;
         frame_done   <= 1'b0;
      end else begin
         fifo_wr_en <= 1'b0;
         frame_done <= 1'b0;
         if (stop && state_q != S_IDLE) stop_pend_q <= 1'b1;
         if (state_q == S_IDLE && start) begin
            base_q      <= fb_base & ALIGN_MASK;
            addr_q      <= fb_base & ALIGN_MASK;
            beat_q      <= '0;
            burst_q     <= '0;
            stop_pend_q <= 1'b0;
            err_q       <= 1'b0;
         end
         if (state_q == S_WAIT && state_d == S_IDLE) stop_pend_q <= 1'b0;
         if (r_hs) begin
            fifo_wr_en   <= 1'b1;
            fifo_wr_data <= m00_axi_rdata;
            beat_q       <= beat_q + 1'b1;
            if (beat_err) err_q <= 1'b1;
            // Frame wrap restarts from the base latched at start.
            if (last_beat) begin
               beat_q <= '0;
               if (burst_q == BURST_LAST) begin
                  burst_q    <= '0;
                  addr_q     <= base_q;
                  frame_done <= 1'b1;
               end else begin
                  burst_q <= burst_q + 1'b1;
                  addr_q  <= addr_q + ADDR_STEP;
               end
            end
         end
      end
   end

endmodule
